// File: rtl/stack_cpu_core.sv
// rtl/stack_cpu_core.sv - parametrised stack processor core with on-chip data stack and req/ready memory port
module stack_cpu_core #(
    parameter int          WIDTH       = 16,
    parameter int          DEPTH       = 8,
    parameter logic [15:0] ENTRY_POINT = 16'h0020
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       mem_ready,
    input  logic [WIDTH-1:0]           mem_rdata,
    output logic                       mem_req,
    output logic                       mem_we,
    output logic [WIDTH-1:0]           mem_addr,
    output logic [WIDTH-1:0]           mem_wdata,
    output logic                       halted,
    output logic                       error,
    output logic [1:0]                 error_code,
    output logic [$clog2(DEPTH+1)-1:0] sp_level,
    output logic [WIDTH-1:0]           tos
);

    localparam int SPW = $clog2(DEPTH + 1);
    localparam int AW  = $clog2(DEPTH);

    localparam logic [5:0] OP_NOP   = 6'h00;
    localparam logic [5:0] OP_PUSH  = 6'h01;
    localparam logic [5:0] OP_POP   = 6'h02;
    localparam logic [5:0] OP_DUP   = 6'h03;
    localparam logic [5:0] OP_SWAP  = 6'h04;
    localparam logic [5:0] OP_ADD   = 6'h08;
    localparam logic [5:0] OP_SUB   = 6'h09;
    localparam logic [5:0] OP_AND   = 6'h0A;
    localparam logic [5:0] OP_OR    = 6'h0B;
    localparam logic [5:0] OP_XOR   = 6'h0C;
    localparam logic [5:0] OP_LOAD  = 6'h10;
    localparam logic [5:0] OP_STORE = 6'h11;
    localparam logic [5:0] OP_JMP   = 6'h18;
    localparam logic [5:0] OP_JZ    = 6'h19;
    localparam logic [5:0] OP_HALT  = 6'h3F;

    typedef enum logic [2:0] {
        S_FETCH,
        S_EXEC,
        S_MEM_RD,
        S_MEM_WR,
        S_HALT,
        S_ERROR
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] ir;
    logic [WIDTH-1:0] stack_mem [DEPTH];
    logic [SPW-1:0]   sp;

    logic [5:0]       opcode;
    logic [WIDTH-1:0] imm;
    logic [SPW-1:0]   sp_m1;
    logic [SPW-1:0]   sp_m2;
    logic [AW-1:0]    top_idx;
    logic [AW-1:0]    nxt_idx;
    logic [AW-1:0]    push_idx;
    logic [WIDTH-1:0] top_val;
    logic [WIDTH-1:0] nxt_val;
    logic [WIDTH-1:0] alu_res;

    logic [SPW-1:0]   need;
    logic             grows;
    logic             illegal;
    logic             fault;
    logic [1:0]       fault_code;
    logic             exec_ok;

    assign opcode   = ir[WIDTH-1 -: 6];
    assign imm      = {6'b0, ir[WIDTH-7:0]};

    // Slot indices wrap harmlessly when the stack is shallow; every use is
    // guarded by the operand check or by sp_level.
    assign sp_m1    = sp - SPW'(1);
    assign sp_m2    = sp - SPW'(2);
    assign top_idx  = sp_m1[AW-1:0];
    assign nxt_idx  = sp_m2[AW-1:0];
    assign push_idx = sp[AW-1:0];
    assign top_val  = stack_mem[top_idx];
    assign nxt_val  = stack_mem[nxt_idx];

    assign sp_level = sp;
    assign tos      = (sp == '0) ? '0 : top_val;
    assign exec_ok  = (state == S_EXEC) && !fault;

    // Decode operand demand and classify faults for the instruction in EXEC
    always_comb begin
        need       = '0;
        grows      = 1'b0;
        illegal    = 1'b0;
        fault      = 1'b0;
        fault_code = 2'd0;
        case (opcode)
            OP_NOP, OP_JMP, OP_HALT: begin
            end
            OP_PUSH:                 grows = 1'b1;
            OP_POP, OP_JZ, OP_LOAD:  need  = SPW'(1);
            OP_DUP: begin
                need  = SPW'(1);
                grows = 1'b1;
            end
            OP_SWAP, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_STORE:
                                     need  = SPW'(2);
            default:                 illegal = 1'b1;
        endcase
        if (illegal) begin
            fault      = 1'b1;
            fault_code = 2'd3;
        end else if (sp < need) begin
            fault      = 1'b1;
            fault_code = 2'd2;
        end else if (grows && (sp == SPW'(DEPTH))) begin
            fault      = 1'b1;
            fault_code = 2'd1;
        end
    end

    // Binary ALU: a = next, b = top, result replaces next
    always_comb begin
        alu_res = '0;
        case (opcode)
            OP_ADD:  alu_res = nxt_val + top_val;
            OP_SUB:  alu_res = nxt_val - top_val;
            OP_AND:  alu_res = nxt_val & top_val;
            OP_OR:   alu_res = nxt_val | top_val;
            OP_XOR:  alu_res = nxt_val ^ top_val;
            default: alu_res = '0;
        endcase
    end

    // Next-state and memory port outputs; rst kills any request combinationally
    always_comb begin
        state_nxt = state;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = pc;
        mem_wdata = '0;
        case (state)
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) state_nxt = S_EXEC;
            end
            S_EXEC: begin
                if (fault) begin
                    state_nxt = S_ERROR;
                end else begin
                    case (opcode)
                        OP_LOAD:  state_nxt = S_MEM_RD;
                        OP_STORE: state_nxt = S_MEM_WR;
                        OP_HALT:  state_nxt = S_HALT;
                        default:  state_nxt = S_FETCH;
                    endcase
                end
            end
            S_MEM_RD: begin
                mem_req  = 1'b1;
                mem_addr = top_val;
                if (mem_ready) state_nxt = S_FETCH;
            end
            S_MEM_WR: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = top_val;
                mem_wdata = nxt_val;
                if (mem_ready) state_nxt = S_FETCH;
            end
            S_HALT, S_ERROR: state_nxt = state;
            default:         state_nxt = S_FETCH;
        endcase
        if (rst) begin
            mem_req = 1'b0;
            mem_we  = 1'b0;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= S_FETCH;
        else     state <= state_nxt;
    end

    // PC, instruction register, stack pointer and sticky status
    always_ff @(posedge clk) begin
        if (rst) begin
            pc         <= WIDTH'(ENTRY_POINT);
            ir         <= '0;
            sp         <= '0;
            halted     <= 1'b0;
            error      <= 1'b0;
            error_code <= 2'd0;
        end else begin
            case (state)
                S_FETCH: if (mem_ready) begin
                    ir <= mem_rdata;
                    pc <= pc + WIDTH'(1);
                end
                S_EXEC: begin
                    if (fault) begin
                        error      <= 1'b1;
                        error_code <= fault_code;
                    end else begin
                        case (opcode)
                            OP_PUSH, OP_DUP: sp <= sp + SPW'(1);
                            OP_POP, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR:
                                             sp <= sp_m1;
                            OP_JMP:          pc <= imm;
                            OP_JZ: begin
                                sp <= sp_m1;
                                if (top_val == '0) pc <= imm;
                            end
                            OP_HALT:         halted <= 1'b1;
                            default: begin
                            end
                        endcase
                    end
                end
                S_MEM_WR: if (mem_ready) sp <= sp_m2;
                default: begin
                end
            endcase
        end
    end

    // Stack register file writes; contents survive reset by design
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (exec_ok) begin
                case (opcode)
                    OP_PUSH: stack_mem[push_idx] <= imm;
                    OP_DUP:  stack_mem[push_idx] <= top_val;
                    OP_SWAP: begin
                        stack_mem[top_idx] <= nxt_val;
                        stack_mem[nxt_idx] <= top_val;
                    end
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR:
                             stack_mem[nxt_idx] <= alu_res;
                    default: begin
                    end
                endcase
            end else if ((state == S_MEM_RD) && mem_ready) begin
                stack_mem[top_idx] <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_stack_cpu_core.sv
// tb/tb_stack_cpu_core.sv - directed self-checking bench for stack_cpu_core
module tb_stack_cpu_core;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_ready = 1'b0;
    logic [15:0] mem_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        halted;
    logic        error;
    logic [1:0]  error_code;
    logic [3:0]  sp_level;
    logic [15:0] tos;

    logic [15:0] mem [256];
    int          wait_states = 0;
    int          wcnt = 0;

    int          passed = 0;
    int          total  = 0;

    int          wr_count = 0;
    logic [15:0] wr_addr = '0;
    logic [15:0] wr_data = '0;
    int          unstable = 0;
    logic        pend = 1'b0;
    logic [15:0] p_addr = '0;
    logic [15:0] p_wdata = '0;
    logic        p_we = 1'b0;

    localparam logic [5:0] NOP = 6'h00, PUSH = 6'h01, ADD = 6'h08, SUB = 6'h09,
                           LOAD = 6'h10, STORE = 6'h11, JZ = 6'h19, HALT = 6'h3F;

    stack_cpu_core #(.WIDTH(16), .DEPTH(8), .ENTRY_POINT(16'h0020)) dut (
        .clk        (clk),
        .rst        (rst),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .halted     (halted),
        .error      (error),
        .error_code (error_code),
        .sp_level   (sp_level),
        .tos        (tos)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[7:0]];

    // Memory responder: inserts wait_states idle cycles before each ready
    always @(posedge clk) begin
        #2;
        if (mem_req) begin
            if (wcnt >= wait_states) begin
                mem_ready = 1'b1;
                wcnt = 0;
            end else begin
                mem_ready = 1'b0;
                wcnt = wcnt + 1;
            end
        end else begin
            mem_ready = 1'b0;
            wcnt = 0;
        end
    end

    // Bus monitor: applies writes to the model and tracks request stability
    always @(negedge clk) begin
        if (mem_req) begin
            if (pend && (mem_addr !== p_addr || mem_we !== p_we ||
                         (mem_we && mem_wdata !== p_wdata)))
                unstable = unstable + 1;
            if (mem_ready) begin
                pend = 1'b0;
                if (mem_we) begin
                    wr_count = wr_count + 1;
                    wr_addr  = mem_addr;
                    wr_data  = mem_wdata;
                    mem[mem_addr[7:0]] = mem_wdata;
                end
            end else begin
                pend    = 1'b1;
                p_addr  = mem_addr;
                p_we    = mem_we;
                p_wdata = mem_wdata;
            end
        end else begin
            pend = 1'b0;
        end
    end

    function automatic logic [15:0] enc(input logic [5:0] op, input logic [9:0] imm);
        return {op, imm};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic hold_reset();
        rst = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        wr_count = 0;
        unstable = 0;
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        logic done;
        done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk);
            if (halted || error) done = 1'b1;
        end
        check({tag, "_terminated"}, done, 1'b1);
    endtask

    initial begin
        logic found;

        // Reset values and arithmetic/halt timing
        wait_states = 0;
        hold_reset();
        mem[8'h20] = enc(PUSH, 10'd5);
        mem[8'h21] = enc(PUSH, 10'd3);
        mem[8'h22] = enc(SUB, 10'd0);
        mem[8'h23] = enc(HALT, 10'd0);
        @(negedge clk);
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_sp_level", sp_level, 4'd0);
        check("rst_tos", tos, 16'h0000);
        check("rst_halted", halted, 1'b0);
        check("rst_error", error, 1'b0);
        check("rst_error_code", error_code, 2'd0);
        release_reset();
        @(negedge clk);
        check("first_fetch_req", mem_req, 1'b1);
        check("first_fetch_addr", mem_addr, 16'h0020);
        check("first_fetch_we", mem_we, 1'b0);
        repeat (7) @(posedge clk);
        @(negedge clk);
        check("halt_not_yet_c7", halted, 1'b0);
        @(posedge clk);
        @(negedge clk);
        check("halt_at_c8", halted, 1'b1);
        check("sub_tos", tos, 16'h0002);
        check("sub_sp", sp_level, 4'd1);
        check("sub_error", error, 1'b0);
        check("halt_mem_req", mem_req, 1'b0);

        // SUB wraps modulo 2^16
        hold_reset();
        mem[8'h20] = enc(PUSH, 10'd3);
        mem[8'h21] = enc(PUSH, 10'd5);
        mem[8'h22] = enc(SUB, 10'd0);
        mem[8'h23] = enc(HALT, 10'd0);
        release_reset();
        wait_done("subwrap", 50);
        check("subwrap_tos", tos, 16'hFFFE);
        check("subwrap_sp", sp_level, 4'd1);

        // Overflow on the ninth PUSH
        hold_reset();
        for (int i = 0; i < 9; i++) mem[8'h20 + i] = enc(PUSH, 10'd1);
        mem[8'h29] = enc(HALT, 10'd0);
        release_reset();
        wait_done("ovf", 100);
        check("ovf_error", error, 1'b1);
        check("ovf_code", error_code, 2'd1);
        check("ovf_sp", sp_level, 4'd8);
        check("ovf_pc", dut.pc, 16'h0029);
        check("ovf_tos", tos, 16'h0001);
        check("ovf_halted", halted, 1'b0);
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("ovf_req_after", mem_req, 1'b0);
        check("ovf_code_sticky", error_code, 2'd1);

        // Underflow: ADD with one entry
        hold_reset();
        mem[8'h20] = enc(PUSH, 10'd7);
        mem[8'h21] = enc(ADD, 10'd0);
        release_reset();
        wait_done("udf", 50);
        check("udf_code", error_code, 2'd2);
        check("udf_tos", tos, 16'h0007);
        check("udf_sp", sp_level, 4'd1);

        // Illegal opcode 0x05
        hold_reset();
        mem[8'h20] = enc(6'h05, 10'd0);
        release_reset();
        wait_done("ill", 50);
        check("ill_error", error, 1'b1);
        check("ill_code", error_code, 2'd3);
        check("ill_sp", sp_level, 4'd0);

        // LOAD latency with zero wait states: 2 + 3 + 2 cycles
        hold_reset();
        mem[8'h90] = 16'h1234;
        mem[8'h20] = enc(PUSH, 10'h090);
        mem[8'h21] = enc(LOAD, 10'd0);
        mem[8'h22] = enc(HALT, 10'd0);
        release_reset();
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("load_lat_c6", halted, 1'b0);
        @(posedge clk);
        @(negedge clk);
        check("load_lat_c7", halted, 1'b1);
        check("load_tos", tos, 16'h1234);

        // STORE then LOAD with three wait states per access
        hold_reset();
        wait_states = 3;
        mem[8'h90] = 16'h1234;
        mem[8'h20] = enc(PUSH, 10'h090);
        mem[8'h21] = enc(LOAD, 10'd0);
        mem[8'h22] = enc(PUSH, 10'h080);
        mem[8'h23] = enc(STORE, 10'd0);
        mem[8'h24] = enc(PUSH, 10'h080);
        mem[8'h25] = enc(LOAD, 10'd0);
        mem[8'h26] = enc(HALT, 10'd0);
        release_reset();
        wait_done("mem", 400);
        check("mem_halted", halted, 1'b1);
        check("mem_error", error, 1'b0);
        check("mem_wr_count", wr_count, 1);
        check("mem_wr_addr", wr_addr, 16'h0080);
        check("mem_wr_data", wr_data, 16'h1234);
        check("mem_stable", unstable, 0);
        check("mem_tos", tos, 16'h1234);
        check("mem_sp", sp_level, 4'd1);

        // Branch taken
        hold_reset();
        wait_states = 0;
        mem[8'h20] = enc(PUSH, 10'd0);
        mem[8'h21] = enc(JZ, 10'h030);
        mem[8'h22] = enc(6'h05, 10'd0);
        mem[8'h30] = enc(HALT, 10'd0);
        release_reset();
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("jz_taken_addr", mem_addr, 16'h0030);
        check("jz_taken_sp", sp_level, 4'd0);
        wait_done("jz_taken", 50);
        check("jz_taken_halted", halted, 1'b1);

        // Branch not taken
        hold_reset();
        mem[8'h20] = enc(NOP, 10'd0);
        mem[8'h21] = enc(NOP, 10'd0);
        mem[8'h22] = enc(PUSH, 10'd7);
        mem[8'h23] = enc(JZ, 10'h030);
        mem[8'h24] = enc(HALT, 10'd0);
        mem[8'h30] = enc(6'h05, 10'd0);
        release_reset();
        repeat (8) @(posedge clk);
        @(negedge clk);
        check("jz_fall_addr", mem_addr, 16'h0024);
        check("jz_fall_sp", sp_level, 4'd0);
        wait_done("jz_fall", 50);
        check("jz_fall_halted", halted, 1'b1);

        // Reset during a stalled MEM_WR
        hold_reset();
        wait_states = 10;
        mem[8'h20] = enc(PUSH, 10'd5);
        mem[8'h21] = enc(PUSH, 10'h080);
        mem[8'h22] = enc(STORE, 10'd0);
        mem[8'h23] = enc(HALT, 10'd0);
        release_reset();
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (mem_we) found = 1'b1;
        end
        check("midrst_reached_wr", found, 1'b1);
        check("midrst_ready_low", mem_ready, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("midrst_req", mem_req, 1'b0);
        check("midrst_we", mem_we, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_fetch_req", mem_req, 1'b1);
        check("midrst_fetch_addr", mem_addr, 16'h0020);
        check("midrst_sp", sp_level, 4'd0);
        check("midrst_error", error, 1'b0);
        check("midrst_no_write", wr_count, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
